ether_import: RTL and testbench
===============================

Name: ether_import

Overview:
- Receive-side counterpart of the ethernet frame exporter.
- Consumes RMII dibits (crsdv/rxd) from the PHY and strips preamble/SFD.
- Parses two frame types: frame-start frames and row frames. Row frames carry a 2-byte row number, then 4-bit grayscale pixels.
- Writes each pixel into a frame-buffer BRAM port at (row << H_BITS) + col and raises status pulses for the host logic.

Parameters:
- DISPLAY_WIDTH, 320, pixels per row.
- DISPLAY_HEIGHT, 240, rows per image.
- H_BITS, 9, column field width in the BRAM address.
- ADDR_BITS, 17, BRAM address width.
- MIN_PREAMBLE, 8, minimum consecutive 2'b01 dibits required before the SFD dibit.

Ports:
- clk_in  input  1  50 MHz RMII reference clock; one dibit per cycle.
- rst_n_in  input  1  asynchronous active-low reset.
- eth_crsdv  input  1  carrier sense / data valid from PHY.
- eth_rxd  input  2  receive dibit, LSB-first within each byte.
- write_addr_out  output  ADDR_BITS  BRAM write address.
- write_data_out  output  4  grayscale pixel.
- write_en_out  output  1  one-cycle write strobe.
- frame_start_out  output  1  pulse: valid frame-start frame received.
- row_done_out  output  1  pulse: a row was fully written.
- frame_done_out  output  1  pulse: row DISPLAY_HEIGHT-1 completed.
- row_err_out  output  1  pulse: row frame truncated (or bad FCS with the optional feature).
- last_row_out  output  16  row number of the most recently accepted row.

Behaviour:
- Reset (async assert, sync deassert internally): all outputs 0; state IDLE; counters 0.
- Inputs eth_crsdv/eth_rxd are registered once; all latencies below count from the registered dibit.
- IDLE: wait for crsdv=1; then go to PREAMBLE with pre_cnt=0.
- PREAMBLE:
  - dibit 01 → pre_cnt++ (saturating).
  - dibit 11 with pre_cnt >= MIN_PREAMBLE → HEADER, cnt=0.
  - any other dibit, or 11 too early → DRAIN.
  - crsdv=0 → IDLE.
- HEADER: collect 8 dibits into hdr[15:0]; dibit k lands in hdr[2k+1:2k].
  - hdr==16'hFFFF → START_BODY.
  - hdr < DISPLAY_HEIGHT → PIXELS with col=0, row=hdr, last_row_out=hdr.
  - otherwise → DRAIN.
  - crsdv=0 during HEADER → IDLE, no pulse.
- START_BODY: count further 2'b11 dibits up to 92 (total 100).
  - The 92nd arrives → frame_start_out pulses one cycle later; then DRAIN.
  - Non-11 dibit or early crsdv=0 → DRAIN/IDLE with no pulse.
- PIXELS: even dibit → data[3:2]; odd dibit → data[1:0].
  - On each odd dibit, in the next cycle: write_en_out=1, write_data_out={hi,lo}, write_addr_out=(row<<H_BITS)+col. col increments.
  - col reaching DISPLAY_WIDTH → row_done_out pulse in the same cycle as the last write. frame_done_out pulses alongside it if row==DISPLAY_HEIGHT-1. Then DRAIN.
  - crsdv=0 before col==DISPLAY_WIDTH → row_err_out pulse, no row_done; pixels already written stay written; → IDLE.
- DRAIN: ignore dibits (FCS, padding, extra pixels) until crsdv=0 → IDLE.
- Pulses are exactly one cycle wide and never coincide with reset.
- Back-to-back frames: at least one crsdv=0 cycle separates them. IDLE re-arms on the first crsdv=1 after that cycle.
- Address arithmetic is done in ADDR_BITS; col uses H_BITS bits and never wraps past DISPLAY_WIDTH-1.
- Reset mid-frame: the current frame is abandoned and no pulses are issued. Frame sync is re-acquired from the next preamble.

Optional Feature:
- Macro: ETH_IMPORT_CRC_EN.
- Defined:
  - Compute CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over header and payload dibits.
  - The 16 dibits preceding crsdv falling are the FCS. The residue must equal 0xC704DD7B.
  - row_done_out/frame_done_out/frame_start_out are deferred to the crsdv falling edge and issued only on CRC pass.
  - On CRC fail, row_err_out pulses instead.
  - BRAM writes still occur immediately.
- Undefined: no CRC logic; pulse timing as in Behaviour; FCS dibits are ignored in DRAIN.

Test Plan:
- 16×01 + 11, hdr FFFF, 92×11, crsdv low → frame_start_out pulses once; no write_en_out.
- Row frame hdr=5, 320 pixels alternating 0xA,0x3 → 320 writes at addr 2560..2879, data A,3,…; row_done_out=1; last_row_out=5.
- Row 239 full frame → row_done_out and frame_done_out pulse on the same cycle.
- Row 7 with crsdv dropped after 100 pixels → 100 writes (3584..3683), row_err_out pulse, no row_done_out.
- Row number 300, or only 4 preamble dibits → no writes, no pulses; next valid row 0 frame is accepted normally.
- rst_n_in low for 1 cycle mid-row 10 → outputs 0 immediately; a later complete row 10 frame writes all 320 pixels correctly.

Source files
------------

// File: rtl/ether_import.sv
// RMII receiver that strips preamble/SFD, parses frame-start and row frames,
// and writes 4-bit pixels to a frame buffer. Optional CRC gating: ETH_IMPORT_CRC_EN.
module ether_import #(
   parameter int DISPLAY_WIDTH  = 320,
   parameter int DISPLAY_HEIGHT = 240,
   parameter int H_BITS         = 9,
   parameter int ADDR_BITS      = 17,
   parameter int MIN_PREAMBLE   = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 eth_crsdv,
   input  logic [1:0]           eth_rxd,
   output logic [ADDR_BITS-1:0] write_addr_out,
   output logic [3:0]           write_data_out,
   output logic                 write_en_out,
   output logic                 frame_start_out,
   output logic                 row_done_out,
   output logic                 frame_done_out,
   output logic                 row_err_out,
   output logic [15:0]          last_row_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_HEADER, S_START_BODY, S_PIXELS, S_DRAIN
   } state_t;

   logic [1:0] rst_sync;
   logic       rst_n;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) rst_sync <= '0;
      else           rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   state_t              state, state_d;
   logic                crsdv_q;
   logic [1:0]          rxd_q;
   logic [7:0]          pre_cnt, pre_cnt_d;
   logic [6:0]          cnt, cnt_d;
   logic [15:0]         hdr, hdr_d, hdr_next, row_d;
   logic [H_BITS-1:0]   col, col_d;
   logic [1:0]          hi, hi_d;
   logic                phase, phase_d;
   logic                wr_en_d, fs_d, rd_d, fd_d, re_d;
   logic                fs_hit, rd_hit, fd_hit;
   logic [ADDR_BITS-1:0] wr_addr_d;
   logic [3:0]          wr_data_d;

`ifdef ETH_IMPORT_CRC_EN
   logic [31:0] crc, crc_d, crc_rev;
   logic [2:0]  pend, pend_d;

   function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 2; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
      return r;
   endfunction
`endif

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state;
      pre_cnt_d = pre_cnt;
      cnt_d     = cnt;
      hdr_d     = hdr;
      row_d     = last_row_out;
      col_d     = col;
      hi_d      = hi;
      phase_d   = phase;
      wr_en_d   = 1'b0;
      wr_addr_d = write_addr_out;
      wr_data_d = write_data_out;
      fs_hit    = 1'b0;
      rd_hit    = 1'b0;
      fd_hit    = 1'b0;
      re_d      = 1'b0;
      fs_d      = 1'b0;
      rd_d      = 1'b0;
      fd_d      = 1'b0;
      hdr_next  = {rxd_q, hdr[15:2]};

      case (state)
         S_IDLE: if (crsdv_q) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = '0;
         end
         S_PREAMBLE: begin
            if (!crsdv_q) state_d = S_IDLE;
            else if (rxd_q == 2'b01) begin
               if (pre_cnt != '1) pre_cnt_d = pre_cnt + 8'd1;
            end else if (rxd_q == 2'b11 && pre_cnt >= 8'(MIN_PREAMBLE)) begin
               state_d = S_HEADER;
               cnt_d   = '0;
            end else state_d = S_DRAIN;
         end
         S_HEADER: begin
            if (!crsdv_q) state_d = S_IDLE;
            else begin
               hdr_d = hdr_next;
               cnt_d = cnt + 7'd1;
               if (cnt == 7'd7) begin
                  cnt_d = '0;
                  if (hdr_next == 16'hFFFF) state_d = S_START_BODY;
                  else if (hdr_next < 16'(DISPLAY_HEIGHT)) begin
                     state_d = S_PIXELS;
                     row_d   = hdr_next;
                     col_d   = '0;
                     phase_d = 1'b0;
                  end else state_d = S_DRAIN;
               end
            end
         end
         S_START_BODY: begin
            if (!crsdv_q) state_d = S_IDLE;
            else if (rxd_q != 2'b11) state_d = S_DRAIN;
            else if (cnt == 7'd91) begin
               fs_hit  = 1'b1;
               state_d = S_DRAIN;
            end else cnt_d = cnt + 7'd1;
         end
         S_PIXELS: begin
            if (!crsdv_q) begin
               re_d    = 1'b1;
               state_d = S_IDLE;
            end else if (!phase) begin
               hi_d    = rxd_q;
               phase_d = 1'b1;
            end else begin
               phase_d   = 1'b0;
               wr_en_d   = 1'b1;
               wr_data_d = {hi, rxd_q};
               wr_addr_d = (ADDR_BITS'(last_row_out) << H_BITS) + ADDR_BITS'(col);
               if (col == H_BITS'(DISPLAY_WIDTH - 1)) begin
                  rd_hit  = 1'b1;
                  fd_hit  = (last_row_out == 16'(DISPLAY_HEIGHT - 1));
                  state_d = S_DRAIN;
               end else col_d = col + H_BITS'(1);
            end
         end
         S_DRAIN: if (!crsdv_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef ETH_IMPORT_CRC_EN
      // Everything after the SFD, FCS included, feeds the CRC; a clean frame leaves the fixed residue.
      crc_d   = crc;
      pend_d  = pend | {fs_hit, rd_hit, fd_hit};
      crc_rev = {<<{crc}};
      if (state == S_PREAMBLE) begin
         crc_d  = '1;
         pend_d = '0;
      end else if (state != S_IDLE && crsdv_q) crc_d = crc_dibit(crc, rxd_q);
      if (state == S_DRAIN && !crsdv_q && pend != '0) begin
         if (crc_rev == 32'hC704DD7B) {fs_d, rd_d, fd_d} = pend;
         else re_d = 1'b1;
         pend_d = '0;
      end
`else
      {fs_d, rd_d, fd_d} = {fs_hit, rd_hit, fd_hit};
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         crsdv_q         <= 1'b0;
         rxd_q           <= '0;
         pre_cnt         <= '0;
         cnt             <= '0;
         hdr             <= '0;
         col             <= '0;
         hi              <= '0;
         phase           <= 1'b0;
         write_addr_out  <= '0;
         write_data_out  <= '0;
         write_en_out    <= 1'b0;
         frame_start_out <= 1'b0;
         row_done_out    <= 1'b0;
         frame_done_out  <= 1'b0;
         row_err_out     <= 1'b0;
         last_row_out    <= '0;
`ifdef ETH_IMPORT_CRC_EN
         crc             <= '1;
         pend            <= '0;
`endif
      end else begin
         state           <= state_d;
         crsdv_q         <= eth_crsdv;
         rxd_q           <= eth_rxd;
         pre_cnt         <= pre_cnt_d;
         cnt             <= cnt_d;
         hdr             <= hdr_d;
         col             <= col_d;
         hi              <= hi_d;
         phase           <= phase_d;
         write_addr_out  <= wr_addr_d;
         write_data_out  <= wr_data_d;
         write_en_out    <= wr_en_d;
         frame_start_out <= fs_d;
         row_done_out    <= rd_d;
         frame_done_out  <= fd_d;
         row_err_out     <= re_d;
         last_row_out    <= row_d;
`ifdef ETH_IMPORT_CRC_EN
         crc             <= crc_d;
         pend            <= pend_d;
`endif
      end
   end

endmodule

// File: tb/tb_ether_import.sv
// Self-checking bench for ether_import: randomized frames against a queue-based model
// of the expected frame-buffer writes and status pulses.
module tb_ether_import;
   localparam int W  = 320;
   localparam int H  = 240;
   localparam int AB = 17;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          eth_crsdv = 1'b0;
   logic [1:0]    eth_rxd = 2'b00;
   logic [AB-1:0] write_addr_out;
   logic [3:0]    write_data_out;
   logic          write_en_out, frame_start_out, row_done_out, frame_done_out, row_err_out;
   logic [15:0]   last_row_out;

   ether_import dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .eth_crsdv(eth_crsdv), .eth_rxd(eth_rxd),
      .write_addr_out(write_addr_out), .write_data_out(write_data_out),
      .write_en_out(write_en_out), .frame_start_out(frame_start_out),
      .row_done_out(row_done_out), .frame_done_out(frame_done_out),
      .row_err_out(row_err_out), .last_row_out(last_row_out)
   );

   always #10 clk_in = ~clk_in;

   int errors = 0;
   int checks = 0;

   logic [AB+3:0] wr_log[$];
   logic [AB+3:0] exp_log[$];
   logic [1:0]    tx[$];
   int fs_cnt, rd_cnt, fd_cnt, re_cnt, rd_no_wr, fd_no_rd;

   always @(negedge clk_in) begin
      if (write_en_out) wr_log.push_back({write_addr_out, write_data_out});
      if (frame_start_out) fs_cnt++;
      if (row_done_out) rd_cnt++;
      if (frame_done_out) fd_cnt++;
      if (row_err_out) re_cnt++;
      if (row_done_out && !write_en_out) rd_no_wr++;
      if (frame_done_out && !row_done_out) fd_no_rd++;
   end

   task automatic clear_logs();
      wr_log.delete();
      exp_log.delete();
      fs_cnt = 0; rd_cnt = 0; fd_cnt = 0; re_cnt = 0; rd_no_wr = 0; fd_no_rd = 0;
   endtask

   task automatic add_preamble(int n);
      repeat (n) tx.push_back(2'b01);
      tx.push_back(2'b11);
   endtask

   task automatic add_word(logic [15:0] w);
      for (int k = 0; k < 8; k++) tx.push_back(w[2*k +: 2]);
   endtask

   // Pixels go out high dibit first; the model entry is the address/data the buffer should see.
   task automatic add_pixels(int row, int n, bit alt, bit expect_wr);
      logic [3:0] p;
      for (int i = 0; i < n; i++) begin
         p = alt ? ((i % 2) ? 4'h3 : 4'hA) : 4'($urandom_range(0, 15));
         tx.push_back(p[3:2]);
         tx.push_back(p[1:0]);
         if (expect_wr) exp_log.push_back({AB'(row * 512 + i), p});
      end
   endtask

   task automatic add_junk(int n);
      for (int i = 0; i < n; i++) tx.push_back(2'($urandom_range(0, 3)));
   endtask

   task automatic send_n(int n, int gap);
      for (int i = 0; i < n && i < tx.size(); i++) begin
         @(negedge clk_in);
         eth_crsdv = 1'b1;
         eth_rxd   = tx[i];
      end
      tx.delete();
      for (int i = 0; i < gap; i++) begin
         @(negedge clk_in);
         eth_crsdv = 1'b0;
         eth_rxd   = 2'b00;
      end
   endtask

   function automatic int bad_writes();
      int bad;
      bad = 0;
      for (int i = 0; i < exp_log.size(); i++)
         if (i >= wr_log.size() || wr_log[i] !== exp_log[i]) bad++;
      return bad;
   endfunction

   task automatic test_reset();
      rst_n_in = 1'b0;
      repeat (3) @(negedge clk_in);
      checks++;
      if ({write_en_out, frame_start_out, row_done_out, frame_done_out, row_err_out} !== 5'b0) begin
         errors++;
         $display("FAIL reset_pulses: got %b want 00000",
                  {write_en_out, frame_start_out, row_done_out, frame_done_out, row_err_out});
      end
      checks++;
      if ({write_addr_out, write_data_out, last_row_out} !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%0d data=%0h last_row=%0d want 0", write_addr_out, write_data_out, last_row_out);
      end
      rst_n_in = 1'b1;
      repeat (5) @(negedge clk_in);
   endtask

   task automatic test_frame_start();
      clear_logs();
      add_preamble(16);
      add_word(16'hFFFF);
      repeat (92) tx.push_back(2'b11);
      add_junk(16);
      send_n(tx.size(), 8);
      checks++;
      if (fs_cnt !== 1) begin errors++; $display("FAIL start_pulse: got %0d want 1", fs_cnt); end
      checks++;
      if (wr_log.size() !== 0) begin errors++; $display("FAIL start_writes: got %0d want 0", wr_log.size()); end
      checks++;
      if (rd_cnt + fd_cnt + re_cnt !== 0) begin
         errors++; $display("FAIL start_other_pulses: got %0d want 0", rd_cnt + fd_cnt + re_cnt);
      end
      // One 11 short of the body length must not count as a frame start.
      clear_logs();
      add_preamble(12);
      add_word(16'hFFFF);
      repeat (91) tx.push_back(2'b11);
      send_n(tx.size(), 8);
      checks++;
      if (fs_cnt !== 0) begin errors++; $display("FAIL start_short: got %0d want 0", fs_cnt); end
   endtask

   task automatic test_row(int row, bit alt);
      clear_logs();
      add_preamble($urandom_range(10, 20));
      add_word(16'(row));
      add_pixels(row, W, alt, 1'b1);
      add_junk($urandom_range(0, 24));
      send_n(tx.size(), 8);
      checks++;
      if (wr_log.size() !== W) begin errors++; $display("FAIL row%0d_count: got %0d want %0d", row, wr_log.size(), W); end
      checks++;
      if (bad_writes() !== 0) begin errors++; $display("FAIL row%0d_data: bad entries %0d want 0", row, bad_writes()); end
      checks++;
      if (rd_cnt !== 1 || rd_no_wr !== 0) begin
         errors++; $display("FAIL row%0d_done: pulses %0d unaligned %0d want 1/0", row, rd_cnt, rd_no_wr);
      end
      checks++;
      if (fd_cnt !== ((row == H - 1) ? 1 : 0) || fd_no_rd !== 0) begin
         errors++; $display("FAIL row%0d_frame_done: pulses %0d unaligned %0d", row, fd_cnt, fd_no_rd);
      end
      checks++;
      if (re_cnt + fs_cnt !== 0) begin errors++; $display("FAIL row%0d_stray: got %0d want 0", row, re_cnt + fs_cnt); end
      checks++;
      if (last_row_out !== 16'(row)) begin errors++; $display("FAIL row%0d_last_row: got %0d want %0d", row, last_row_out, row); end
   endtask

   task automatic test_truncated();
      clear_logs();
      add_preamble(16);
      add_word(16'd7);
      add_pixels(7, 100, 1'b0, 1'b1);
      send_n(tx.size(), 8);
      checks++;
      if (wr_log.size() !== 100) begin errors++; $display("FAIL trunc_count: got %0d want 100", wr_log.size()); end
      checks++;
      if (bad_writes() !== 0) begin errors++; $display("FAIL trunc_data: bad entries %0d want 0", bad_writes()); end
      checks++;
      if (re_cnt !== 1 || rd_cnt !== 0) begin errors++; $display("FAIL trunc_pulses: err %0d done %0d want 1/0", re_cnt, rd_cnt); end
   endtask

   task automatic test_rejects();
      int bad_hdr[2] = '{300, 240};
      foreach (bad_hdr[j]) begin
         clear_logs();
         add_preamble(16);
         add_word(16'(bad_hdr[j]));
         add_pixels(0, W, 1'b0, 1'b0);
         send_n(tx.size(), 8);
         checks++;
         if (wr_log.size() + rd_cnt + fd_cnt + re_cnt + fs_cnt !== 0) begin
            errors++; $display("FAIL reject_hdr%0d: events %0d want 0", bad_hdr[j], wr_log.size() + rd_cnt + re_cnt + fs_cnt);
         end
         checks++;
         if (last_row_out !== 16'd7) begin errors++; $display("FAIL reject_hdr%0d_last_row: got %0d want 7", bad_hdr[j], last_row_out); end
      end
      clear_logs();
      add_preamble(4);
      add_word(16'd0);
      add_pixels(0, W, 1'b0, 1'b0);
      send_n(tx.size(), 8);
      checks++;
      if (wr_log.size() + rd_cnt + fd_cnt + re_cnt + fs_cnt !== 0) begin
         errors++; $display("FAIL reject_short_pre: events %0d want 0", wr_log.size() + rd_cnt + re_cnt + fs_cnt);
      end
      test_row(0, 1'b0);
   endtask

   task automatic test_mid_reset();
      clear_logs();
      add_preamble(16);
      add_word(16'd10);
      add_pixels(10, W, 1'b0, 1'b0);
      send_n(25 + 200, 0);
      @(negedge clk_in);
      rst_n_in = 1'b0;
      #1;
      checks++;
      if ({write_en_out, row_done_out, frame_done_out, row_err_out, frame_start_out} !== 5'b0 ||
          last_row_out !== 16'd0 || write_addr_out !== '0) begin
         errors++; $display("FAIL midreset_outputs: en=%b last_row=%0d addr=%0d want 0", write_en_out, last_row_out, write_addr_out);
      end
      @(negedge clk_in);
      rst_n_in  = 1'b1;
      eth_crsdv = 1'b0;
      repeat (6) @(negedge clk_in);
      checks++;
      if (re_cnt + rd_cnt + fs_cnt !== 0) begin errors++; $display("FAIL midreset_pulses: got %0d want 0", re_cnt + rd_cnt + fs_cnt); end
      test_row(10, 1'b0);
   endtask

   task automatic test_back_to_back();
      clear_logs();
      add_preamble(12);
      add_word(16'd20);
      add_pixels(20, W, 1'b0, 1'b1);
      send_n(tx.size(), 1);
      add_preamble(12);
      add_word(16'd21);
      add_pixels(21, W, 1'b0, 1'b1);
      send_n(tx.size(), 8);
      checks++;
      if (wr_log.size() !== 2 * W) begin errors++; $display("FAIL b2b_count: got %0d want %0d", wr_log.size(), 2 * W); end
      checks++;
      if (bad_writes() !== 0) begin errors++; $display("FAIL b2b_data: bad entries %0d want 0", bad_writes()); end
      checks++;
      if (rd_cnt !== 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", rd_cnt); end
   endtask

   initial begin
      test_reset();
      test_frame_start();
      test_row(5, 1'b1);
      test_row(H - 1, 1'b0);
      test_row($urandom_range(1, H - 2), 1'b0);
      test_truncated();
      test_rejects();
      test_mid_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
